wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 83 ++++++++
 tb/tb_wb_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage register file: 16x16 registers with R0 hardwired to zero, two combinational
// read ports, writeback source mux and a retire counter. Define WB_REGFILE_BYPASS_EN for write-to-read bypass.
module wb_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] wb_alu_result,
  input  logic [15:0] wb_read_data,
  input  logic [3:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        wb_mem_to_reg,
  input  logic [3:0]  rs1_addr,
  input  logic [3:0]  rs2_addr,
  output logic [15:0] rs1_data,
  output logic [15:0] rs2_data,
  output logic [15:0] wb_data,
  input  logic        retire_clr,
  output logic [15:0] retire_count
);

  logic [15:0][15:0] reg_q;
  logic [1:0][3:0]   rd_addr;
  logic [1:0][15:0]  rd_data;
  logic [15:0]       retire_count_reg;
  logic [15:0]       retire_count_next;

  assign wb_data = wb_mem_to_reg ? wb_read_data : wb_alu_result;

  // Entry 0 never gets a write enable, so it stays at its reset value of zero.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      logic [15:0] r_reg;
      logic        we;
      assign we = wb_reg_write && (wb_rd == 4'(gi)) && (gi != 0);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_reg <= '0;
        end else if (we) begin
          r_reg <= wb_data;
        end
      end
      assign reg_q[gi] = r_reg;
    end
  endgenerate

  assign rd_addr  = {rs2_addr, rs1_addr};
  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rd_data[gi] = (rd_addr[gi] == 4'd0) ? 16'h0000 : reg_q[rd_addr[gi]];
`ifdef WB_REGFILE_BYPASS_EN
        // Bypass is gated by rst_n so every read returns zero while reset is held.
        if (rst_n && wb_reg_write && (wb_rd == rd_addr[gi]) && (wb_rd != 4'd0)) begin
          rd_data[gi] = wb_data;
        end
`endif
      end
    end
  endgenerate

  always_comb begin
    retire_count_next = retire_count_reg;
    if (retire_clr) begin
      retire_count_next = 16'h0000;
    end else if (wb_reg_write) begin
      retire_count_next = retire_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count_reg <= '0;
    end else begin
      retire_count_reg <= retire_count_next;
    end
  end

  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand-written corner sequences
// and randomized traffic compared against an array-based reference model.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [15:0] wb_alu_result;
  logic [15:0] wb_read_data;
  logic [3:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic [15:0] wb_data;
  logic        retire_clr;
  logic [15:0] retire_count;

  int checks = 0;
  int failures = 0;

  logic [15:0] model_mem [16];
  int          model_cnt;

  wb_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_alu_result (wb_alu_result),
    .wb_read_data  (wb_read_data),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_data       (wb_data),
    .retire_clr    (retire_clr),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        m2r;
    logic [3:0]  rd;
    logic [15:0] alu;
    logic [15:0] rdata;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        clr;
    logic [15:0] exp_wb;
    logic [15:0] exp_rs1;
    logic [15:0] exp_rs2;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
    model_cnt = 0;
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] a);
    logic [15:0] v;
    v = (a == 4'd0) ? 16'h0000 : model_mem[a];
`ifdef WB_REGFILE_BYPASS_EN
    if (rst_n && wb_reg_write && wb_rd == a && a != 4'd0)
      v = wb_mem_to_reg ? wb_read_data : wb_alu_result;
`endif
    return v;
  endfunction

  task automatic drive(input logic we, input logic m2r, input logic [3:0] rd,
                       input logic [15:0] alu, input logic [15:0] rdata,
                       input logic [3:0] a1, input logic [3:0] a2, input logic clr);
    @(negedge clk);
    wb_reg_write  = we;
    wb_mem_to_reg = m2r;
    wb_rd         = rd;
    wb_alu_result = alu;
    wb_read_data  = rdata;
    rs1_addr      = a1;
    rs2_addr      = a2;
    retire_clr    = clr;
    #2;
  endtask

  // Advance past the rising edge and apply the architectural effect of the transaction.
  task automatic commit();
    logic [15:0] v;
    v = wb_mem_to_reg ? wb_read_data : wb_alu_result;
    @(posedge clk);
    if (wb_reg_write && wb_rd != 4'd0) model_mem[wb_rd] = v;
    if (retire_clr) model_cnt = 0;
    else if (wb_reg_write) model_cnt = (model_cnt + 1) % 65536;
  endtask

  task automatic txn(input string name, input logic we, input logic m2r, input logic [3:0] rd,
                     input logic [15:0] alu, input logic [15:0] rdata,
                     input logic [3:0] a1, input logic [3:0] a2, input logic clr);
    drive(we, m2r, rd, alu, rdata, a1, a2, clr);
    chk({name, ".wb_data"}, wb_data, m2r ? rdata : alu);
    chk({name, ".rs1"}, rs1_data, model_read(a1));
    chk({name, ".rs2"}, rs2_data, model_read(a2));
    chk({name, ".cnt"}, retire_count, 16'(model_cnt));
    $display("txn %s we=%0d rd=%0d wb=%04h rs1[%0d]=%04h rs2[%0d]=%04h cnt=%04h",
             name, we, rd, wb_data, a1, rs1_data, a2, rs2_data, retire_count);
    commit();
  endtask

  initial begin
    //            we   m2r  rd  alu       rdata     rs1 rs2 clr  wb        rs1       rs2       cnt
    vecs[0] = '{1'b1,1'b0,4'd3,16'h1234,16'h0000,4'd0,4'd0,1'b0,16'h1234,16'h0000,16'h0000,16'h0000};
    vecs[1] = '{1'b0,1'b0,4'd0,16'h0000,16'h0000,4'd3,4'd0,1'b0,16'h0000,16'h1234,16'h0000,16'h0001};
    vecs[2] = '{1'b1,1'b0,4'd0,16'hBEEF,16'h0000,4'd0,4'd3,1'b0,16'hBEEF,16'h0000,16'h1234,16'h0001};
    vecs[3] = '{1'b0,1'b0,4'd0,16'h0000,16'h0000,4'd0,4'd0,1'b0,16'h0000,16'h0000,16'h0000,16'h0002};
    vecs[4] = '{1'b1,1'b1,4'd7,16'h0F0F,16'hA5A5,4'd3,4'd3,1'b0,16'hA5A5,16'h1234,16'h1234,16'h0002};
    vecs[5] = '{1'b0,1'b0,4'd0,16'h0000,16'h0000,4'd7,4'd3,1'b0,16'h0000,16'hA5A5,16'h1234,16'h0003};
    vecs[6] = '{1'b0,1'b1,4'd0,16'hFFFF,16'h0042,4'd7,4'd7,1'b0,16'h0042,16'hA5A5,16'hA5A5,16'h0003};
    vecs[7] = '{1'b1,1'b0,4'd3,16'h0001,16'h0000,4'd7,4'd0,1'b1,16'h0001,16'hA5A5,16'h0000,16'h0003};
    vecs[8] = '{1'b0,1'b0,4'd0,16'h0000,16'h0000,4'd3,4'd7,1'b0,16'h0000,16'h0001,16'hA5A5,16'h0000};

    rst_n = 1'b0;
    wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0; wb_rd = 4'd0;
    wb_alu_result = 16'h0; wb_read_data = 16'h0;
    rs1_addr = 4'd0; rs2_addr = 4'd0; retire_clr = 1'b0;
    model_reset();

    // Reset state: every address reads zero, even with a write pending during reset.
    #3;
    wb_reg_write = 1'b1; wb_rd = 4'd4; wb_alu_result = 16'hDEAD;
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i); rs2_addr = 4'(15 - i);
      #1;
      chk("reset.rs1", rs1_data, 16'h0000);
      chk("reset.rs2", rs2_data, 16'h0000);
    end
    chk("reset.cnt", retire_count, 16'h0000);
    @(posedge clk);
    #1;
    rs1_addr = 4'd4;
    #1;
    chk("reset.write_ignored", rs1_data, 16'h0000);
    $display("txn reset_hold rs1[4]=%04h cnt=%04h", rs1_data, retire_count);
    @(negedge clk);
    wb_reg_write = 1'b0;
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].m2r, vecs[i].rd, vecs[i].alu, vecs[i].rdata,
            vecs[i].rs1, vecs[i].rs2, vecs[i].clr);
      chk($sformatf("vec%0d.wb_data", i), wb_data, vecs[i].exp_wb);
      chk($sformatf("vec%0d.rs1", i), rs1_data, vecs[i].exp_rs1);
      chk($sformatf("vec%0d.rs2", i), rs2_data, vecs[i].exp_rs2);
      chk($sformatf("vec%0d.cnt", i), retire_count, vecs[i].exp_cnt);
      $display("txn vec%0d we=%0d rd=%0d wb=%04h rs1=%04h rs2=%04h cnt=%04h",
               i, vecs[i].we, vecs[i].rd, wb_data, rs1_data, rs2_data, retire_count);
      commit();
    end

    // Same-cycle write/read of R5: bypass build sees the new value, default build the old one.
    txn("r5_pre", 1'b1, 1'b0, 4'd5, 16'h0001, 16'h0000, 4'd0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 4'd5, 16'h0002, 16'h0000, 4'd0, 4'd5, 1'b0);
`ifdef WB_REGFILE_BYPASS_EN
    chk("r5_same_cycle", rs2_data, 16'h0002);
`else
    chk("r5_same_cycle", rs2_data, 16'h0001);
`endif
    $display("txn r5_same_cycle rs2[5]=%04h", rs2_data);
    commit();
    txn("r5_after", 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd5, 4'd5, 1'b0);
    // R0 is never bypassed in either build.
    txn("r0_nobyp", 1'b1, 1'b0, 4'd0, 16'h7777, 16'h0000, 4'd0, 4'd0, 1'b0);
    chk("r0_nobyp.direct", rs1_data, 16'h0000);

    // Retire counter wrap: clear, count 65535 writes to R0, then one more wraps to zero.
    txn("wrap_clr", 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    wb_reg_write = 1'b1; wb_rd = 4'd0; retire_clr = 1'b0;
    repeat (65535) @(posedge clk);
    model_cnt = (model_cnt + 65535) % 65536;
    txn("wrap_ffff", 1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0);
    txn("wrap_zero", 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0);
    chk("wrap_zero.direct", retire_count, 16'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 15) == 0));
    end

    // Mid-cycle asynchronous reset while R9 holds 0x5555.
    txn("r9_set", 1'b1, 1'b0, 4'd9, 16'h5555, 16'h0000, 4'd0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd9, 4'd9, 1'b0);
    chk("r9_before_rst", rs1_data, 16'h5555);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r9_async_rst", rs1_data, 16'h0000);
    chk("cnt_async_rst", retire_count, 16'h0000);
    $display("txn async_rst rs1[9]=%04h cnt=%04h", rs1_data, retire_count);
    @(negedge clk);
    rst_n = 1'b1;
    txn("post_rst_wr", 1'b1, 1'b0, 4'd9, 16'h00A1, 16'h0000, 4'd9, 4'd0, 1'b0);
    txn("post_rst_rd", 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd9, 4'd9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
